fir_coef_bank: RTL and testbench

Double-buffered coefficient store that serves the FIR tap engine's coefficient fetch: it answers the tap's `coef_addr` with a registered `coefficients` word from the active bank. A host-side writer loads a new coefficient set into the shadow bank. A bank swap is deferred to the next sample strobe so a filter pass never mixes old and new sets. It sits between the control/register path and the FIR tap, alongside the multiplier and accumulator.

---
 rtl/fir_coef_bank.sv | 201 ++++++++++++++++++++
 tb/tb_fir_coef_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coef_bank
//  Purpose  : Double-buffered FIR coefficient store. The FIR tap reads the
//             active bank through a registered port. A host-side writer fills
//             the shadow bank, and a requested bank swap takes effect on the
//             next sample strobe so that no filter pass mixes two sets.
//  Ports    : clk, reset (async, active-high)
//             data_en         sample strobe, marks the swap boundary
//             coef_addr       tap read address
//             coefficients    registered read data (0 when out of range)
//             wr_start        restart the load of the shadow bank
//             wr_en, wr_data  write one coefficient at the write pointer
//             swap_req        arm a bank swap once the load is complete
//             load_done       shadow bank holds a complete set
//             swap_pending    swap armed, waiting for data_en
//             active_bank     index of the bank being read
//             wr_overflow     sticky: a write hit a full or frozen shadow
//  Revision : 1.0  initial release
// ============================================================================
module fir_coef_bank #(
    parameter int NUM_TAPS = 16,
    parameter int ADDR_W   = 8,
    parameter int COEF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_en,
    input  logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coefficients,
    input  logic              wr_start,
    input  logic              wr_en,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              load_done,
    output logic              swap_pending,
    output logic              active_bank,
    output logic              wr_overflow
);

    localparam int c_LAST = NUM_TAPS - 1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_LOADING      = 2'd1,
        S_LOADED       = 2'd2,
        S_SWAP_PENDING = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_write;
    logic              w_swap;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_active;
    logic [COEF_W-1:0] r_coef;
    logic [COEF_W-1:0] w_rd_data;
    logic              w_last;

    logic [COEF_W-1:0] r_bank [2][NUM_TAPS];

    assign w_last = (32'(r_ptr) == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, write-pointer and flag decode. wr_start takes priority
    // over everything: it restarts the load (cancelling any armed swap),
    // and a write in the same cycle lands at index 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_idx    = r_ptr;
        w_write     = 1'b0;
        w_swap      = 1'b0;
        w_ovf_nxt   = r_ovf;

        if (wr_start) begin
            w_ovf_nxt = 1'b0;
            w_wr_idx  = '0;
            if (wr_en) begin
                w_write     = 1'b1;
                w_ptr_nxt   = ADDR_W'(1);
                w_state_nxt = (NUM_TAPS == 1) ? S_LOADED : S_LOADING;
            end else begin
                w_ptr_nxt   = '0;
                w_state_nxt = S_LOADING;
            end
        end else begin
            case (r_state)
                S_LOADING: begin
                    if (wr_en) begin
                        w_write   = 1'b1;
                        w_ptr_nxt = r_ptr + ADDR_W'(1);
                        if (w_last) begin
                            w_state_nxt = S_LOADED;
                        end
                    end
                end
                S_LOADED: begin
                    // The arming cycle never swaps, even with data_en high.
                    if (swap_req) begin
                        w_state_nxt = S_SWAP_PENDING;
                    end
                end
                S_SWAP_PENDING: begin
                    if (data_en) begin
                        w_swap      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
            if (wr_en && (r_state != S_LOADING)) begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer, sticky overflow and active-bank registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_ovf    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_ovf <= w_ovf_nxt;
            if (w_swap) begin
                r_active <= ~r_active;
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient storage. Writes only ever target the shadow bank; a
    // write and a swap can never occur in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_bank[b][t] <= '0;
                end
            end
        end else if (w_write) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                if (w_wr_idx == ADDR_W'(t)) begin
                    r_bank[~r_active][t] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: addresses at or beyond NUM_TAPS match no entry and
    // therefore return zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if (coef_addr == ADDR_W'(t)) begin
                w_rd_data = r_bank[r_active][t];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_coef <= '0;
        end else begin
            r_coef <= w_rd_data;
        end
    end

    assign coefficients = r_coef;
    assign load_done    = (r_state == S_LOADED) || (r_state == S_SWAP_PENDING);
    assign swap_pending = (r_state == S_SWAP_PENDING);
    assign active_bank  = r_active;
    assign wr_overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_coef_bank
//  Purpose  : Self-checking bench for fir_coef_bank (NUM_TAPS = 16).
//             Table-driven read checks plus directed multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_coef_bank;

    logic        clk;
    logic        reset;
    logic        data_en;
    logic [7:0]  coef_addr;
    logic [15:0] coefficients;
    logic        wr_start;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        load_done;
    logic        swap_pending;
    logic        active_bank;
    logic        wr_overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] addr;
        logic       in_range;
    } vec_t;

    vec_t tbl[8];

    fir_coef_bank #(
        .NUM_TAPS (16),
        .ADDR_W   (8),
        .COEF_W   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_en      (data_en),
        .coef_addr    (coef_addr),
        .coefficients (coefficients),
        .wr_start     (wr_start),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .load_done    (load_done),
        .swap_pending (swap_pending),
        .active_bank  (active_bank),
        .wr_overflow  (wr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write a full 16-entry set base+i. With 'combined' the first write
    // shares its cycle with wr_start.
    task automatic load_set(input logic [15:0] base, input bit combined);
        if (combined) begin
            wr_start = 1'b1;
            wr_en    = 1'b1;
            wr_data  = base;
            tick();
            wr_start = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (i == 15) check("load_done_before_last", {31'd0, load_done}, 32'd0);
                wr_data = base + 16'(i);
                tick();
            end
        end else begin
            wr_start = 1'b1;
            tick();
            wr_start = 1'b0;
            wr_en    = 1'b1;
            for (int i = 0; i < 16; i++) begin
                wr_data = base + 16'(i);
                tick();
            end
        end
        wr_en = 1'b0;
        check("load_done_after_last", {31'd0, load_done}, 32'd1);
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [15:0] exp);
        coef_addr = addr;
        tick();
        check(name, {16'd0, coefficients}, {16'd0, exp});
    endtask

    task automatic read_table(input string name, input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            read_chk(name, tbl[i].addr,
                     tbl[i].in_range ? (base + 16'(tbl[i].addr)) : 16'h0000);
        end
    endtask

    task automatic arm_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap_pending_armed", {31'd0, swap_pending}, 32'd1);
    endtask

    task automatic fire_swap(input logic exp_bank);
        data_en = 1'b1;
        tick();
        data_en = 1'b0;
        check("active_bank_after_swap", {31'd0, active_bank}, {31'd0, exp_bank});
        check("swap_pending_cleared", {31'd0, swap_pending}, 32'd0);
        check("load_done_cleared", {31'd0, load_done}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_coef"}, {16'd0, coefficients}, 32'd0);
        check({name, "_bank"}, {31'd0, active_bank}, 32'd0);
        check({name, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({name, "_swap_pending"}, {31'd0, swap_pending}, 32'd0);
        check({name, "_wr_overflow"}, {31'd0, wr_overflow}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'd0,   1'b1};
        tbl[1] = '{8'd5,   1'b1};
        tbl[2] = '{8'd7,   1'b1};
        tbl[3] = '{8'd15,  1'b1};
        tbl[4] = '{8'd16,  1'b0};
        tbl[5] = '{8'd20,  1'b0};
        tbl[6] = '{8'd255, 1'b0};
        tbl[7] = '{8'd10,  1'b1};

        reset     = 1'b1;
        data_en   = 1'b0;
        coef_addr = '0;
        wr_start  = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        swap_req  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset state: every address reads 0, all flags low.
        check_all_zero("reset");
        for (int a = 0; a < 16; a++) begin
            read_chk("reset_sweep", 8'(a), 16'h0000);
        end

        // Set A into bank 1, swap, read back.
        load_set(16'h0100, 1'b0);
        arm_swap();
        check("bank_before_swap", {31'd0, active_bank}, 32'd0);
        fire_swap(1'b1);
        read_chk("A_addr5", 8'd5, 16'h0105);
        read_chk("A_addr20", 8'd20, 16'h0000);
        read_table("A_table", 16'h0100);

        // Set B into bank 0 (combined wr_start+wr_en), swap held off 50 cycles.
        load_set(16'h0200, 1'b1);
        arm_swap();
        repeat (50) tick();
        check("hold_pending", {31'd0, swap_pending}, 32'd1);
        check("hold_bank", {31'd0, active_bank}, 32'd1);
        read_table("hold_reads_A", 16'h0100);
        fire_swap(1'b0);
        read_table("B_table", 16'h0200);

        // Set C into bank 1, then an extra write overflows.
        load_set(16'h0300, 1'b0);
        check("ovf_before", {31'd0, wr_overflow}, 32'd0);
        wr_en   = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        check("ovf_set", {31'd0, wr_overflow}, 32'd1);
        check("ovf_load_done", {31'd0, load_done}, 32'd1);

        // swap_req and data_en together only arm the swap.
        swap_req = 1'b1;
        data_en  = 1'b1;
        tick();
        swap_req = 1'b0;
        data_en  = 1'b0;
        check("arm_only_pending", {31'd0, swap_pending}, 32'd1);
        check("arm_only_bank", {31'd0, active_bank}, 32'd0);
        fire_swap(1'b1);
        read_table("C_table", 16'h0300);
        check("ovf_sticky", {31'd0, wr_overflow}, 32'd1);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check("ovf_cleared", {31'd0, wr_overflow}, 32'd0);

        // Set D into bank 0, armed; a stray write sets overflow; then async reset.
        load_set(16'h0400, 1'b0);
        arm_swap();
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pending_ovf", {31'd0, wr_overflow}, 32'd1);
        coef_addr = 8'd3;
        tick();
        check("pre_reset_coef", {16'd0, coefficients}, 32'h0303);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset_pending");
        @(negedge clk);
        reset = 1'b0;

        // Mid-load (ptr = 7) async reset.
        tick();
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        wr_en    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 16'h0450 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        check("midload_not_done", {31'd0, load_done}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset_midload");
        @(negedge clk);
        reset = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            read_chk("post_reset_sweep", 8'(a), 16'h0000);
        end

        // A fresh full load and swap still works after reset.
        load_set(16'h0500, 1'b0);
        arm_swap();
        fire_swap(1'b1);
        read_table("E_table", 16'h0500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
